// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush controller: stall and flush-cause
// values, register-bus width, stall vector bit positions and the controller FSM state type.
package pipeline_ctrl_pkg;

  localparam int REG_BUS = 32;
  localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic EXCEPTION = 1'b1;
  localparam logic FAILED    = 1'b0;

  localparam int STALL_W  = 4;
  localparam int STALL_IF = 0;
  localparam int STALL_ID = 1;
  localparam int STALL_EX = 2;
  localparam int STALL_CM = 3;

  typedef enum logic {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } ctrl_state_e;

  // A stalled stage also stops every stage upstream of it.
  function automatic logic [STALL_W-1:0] stall_upto(input int top);
    logic [STALL_W-1:0] m;
    m = {STALL_W{NO_STOP}};
    for (int i = 0; i < STALL_W; i++) begin
      if (i <= top) m[i] = STOP;
    end
    return m;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_stall_watchdog.sv
// Stall statistics: free-running stall-cycle counter and a saturating run counter
// that raises a sticky flag when the pipeline has been stalled for TIMEOUT cycles.
module stall_watchdog
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_active,
  input  logic               flush,
  output logic [REG_BUS-1:0] stall_cycles,
  output logic               stall_timeout
);

  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0]   run_q, run_d;
  logic               timeout_q, timeout_d;
  logic [REG_BUS-1:0] cycles_q, cycles_d;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    run_d     = '0;
    timeout_d = timeout_q | (run_q == RUN_MAX);
    cycles_d  = cycles_q;
    if (stall_active) begin
      cycles_d = cycles_q + REG_BUS'(1);
    end
    if (stall_active && !flush) begin
      run_d = (run_q == RUN_MAX) ? run_q : run_q + CNT_W'(1);
    end
  end

  // NOTE: state updates use non-blocking assignments so all registers sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q     <= '0;
      timeout_q <= 1'b0;
      cycles_q  <= ZERO_WORD;
    end else begin
      run_q     <= run_d;
      timeout_q <= timeout_d;
      cycles_q  <= cycles_d;
    end
  end

  assign stall_cycles  = cycles_q;
  assign stall_timeout = timeout_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the dual-issue pipeline: merges stage stall
// requests, arbitrates exception vs mispredict flushes and holds fetch until redirect ack.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_if,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic               stallreq_cm,
  input  logic               exc_req,
  input  logic               exc_inst_sel,
  input  logic [REG_BUS-1:0] exc_target,
  input  logic               bp_fail,
  input  logic [REG_BUS-1:0] bp_target,
  input  logic               redirect_ack,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic               flush_cause,
  output logic               exception_inst_sel,
  output logic [REG_BUS-1:0] new_pc,
  output logic [REG_BUS-1:0] stall_cycles,
  output logic               stall_timeout
);

  ctrl_state_e        state_q;
  logic [REG_BUS-1:0] target_q;
  logic [STALL_W-1:0] merged;

  always_comb begin
    if (stallreq_cm)      merged = stall_upto(STALL_CM);
    else if (stallreq_ex) merged = stall_upto(STALL_EX);
    else if (stallreq_id) merged = stall_upto(STALL_ID);
    else if (stallreq_if) merged = stall_upto(STALL_IF);
    else                  merged = {STALL_W{NO_STOP}};
  end

  // Exceptions flush in either state; a mispredict only while not already redirecting.
  always_comb begin
    flush              = 1'b0;
    flush_cause        = FAILED;
    exception_inst_sel = 1'b0;
    new_pc             = target_q;
    stall              = merged;
    if (exc_req) begin
      flush              = 1'b1;
      flush_cause        = EXCEPTION;
      exception_inst_sel = exc_inst_sel;
      new_pc             = exc_target;
    end else if (state_q == RUN && bp_fail) begin
      flush       = 1'b1;
      flush_cause = FAILED;
      new_pc      = bp_target;
    end
    if (flush) begin
      stall = {STALL_W{NO_STOP}};
    end else if (state_q == REDIRECT && !redirect_ack) begin
      stall[STALL_IF] = STOP;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      target_q <= ZERO_WORD;
    end else if (flush) begin
      state_q  <= REDIRECT;
      target_q <= new_pc;
    end else if (state_q == REDIRECT && redirect_ack) begin
      state_q  <= RUN;
    end
  end

  stall_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk           (clk),
    .rst           (rst),
    .stall_active  (|stall),
    .flush         (flush),
    .stall_cycles  (stall_cycles),
    .stall_timeout (stall_timeout)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: merge table, directed redirect/watchdog
// sequences and randomized traffic against a behavioural model.
module tb_pipeline_ctrl;

  localparam int T = 7;

  logic        clk, rst;
  logic        r_if, r_id, r_ex, r_cm;
  logic        exc, esel, bp, ack;
  logic [31:0] etgt, btgt;
  logic [3:0]  stall;
  logic        flush, flush_cause, exception_inst_sel, stall_timeout;
  logic [31:0] new_pc, stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  bit          m_redir;
  logic [31:0] m_target;
  logic [31:0] m_cycles;
  int          m_run;
  bit          m_tout;

  typedef struct {
    logic [3:0] req;   // {cm, ex, id, if}
    logic [3:0] exp_stall;
  } merge_vec_t;

  pipeline_ctrl #(.TIMEOUT(T), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(r_if), .stallreq_id(r_id), .stallreq_ex(r_ex), .stallreq_cm(r_cm),
    .exc_req(exc), .exc_inst_sel(esel), .exc_target(etgt),
    .bp_fail(bp), .bp_target(btgt), .redirect_ack(ack),
    .stall(stall), .flush(flush), .flush_cause(flush_cause),
    .exception_inst_sel(exception_inst_sel), .new_pc(new_pc),
    .stall_cycles(stall_cycles), .stall_timeout(stall_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Highest requesting stage k stops stages 0..k: mask = 2^(k+1)-1.
  function automatic logic [3:0] merge_model(input logic [3:0] r);
    for (int k = 3; k >= 0; k--) if (r[k]) return 4'((1 << (k + 1)) - 1);
    return 4'b0000;
  endfunction

  task automatic clear_inputs();
    {r_if, r_id, r_ex, r_cm, exc, esel, bp, ack} = '0;
    etgt = 32'h0;
    btgt = 32'h0;
  endtask

  // Checks combinational outputs for the current inputs, clocks once, checks counters.
  task automatic step(input string tag);
    logic [3:0]  es;
    logic        ef, ec, esl;
    logic [31:0] epc;
    #1;
    es  = merge_model({r_cm, r_ex, r_id, r_if});
    ef  = 1'b0; ec = 1'b0; esl = 1'b0; epc = m_target;
    if (exc) begin
      ef = 1'b1; ec = 1'b1; esl = esel; epc = etgt; es = 4'b0000;
    end else if (!m_redir && bp) begin
      ef = 1'b1; epc = btgt; es = 4'b0000;
    end else if (m_redir && !ack) begin
      es = es | 4'b0001;
    end
    check({tag, "/flush"}, 32'(flush), 32'(ef));
    check({tag, "/stall"}, 32'(stall), 32'(es));
    if (ef) begin
      check({tag, "/cause"}, 32'(flush_cause), 32'(ec));
      check({tag, "/exc_sel"}, 32'(exception_inst_sel), 32'(esl));
    end
    if (ef || m_redir) check({tag, "/new_pc"}, new_pc, epc);
    @(posedge clk);
    if (ef) begin
      m_redir = 1'b1;
      m_target = epc;
    end else if (m_redir && ack) begin
      m_redir = 1'b0;
    end
    if (m_run >= T) m_tout = 1'b1;
    m_run = (es != 0) ? m_run + 1 : 0;
    if (es != 0) m_cycles = m_cycles + 32'd1;
    #1;
    check({tag, "/stall_cycles"}, stall_cycles, m_cycles);
    check({tag, "/timeout"}, 32'(stall_timeout), 32'(m_tout));
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    #1;
    check("rst/stall", 32'(stall), 32'h0);
    check("rst/flush", 32'(flush), 32'h0);
    check("rst/new_pc", new_pc, 32'h0);
    check("rst/stall_cycles", stall_cycles, 32'h0);
    check("rst/timeout", 32'(stall_timeout), 32'h0);
    m_redir = 1'b0; m_target = 32'h0; m_cycles = 32'h0; m_run = 0; m_tout = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  merge_vec_t tbl[16];

  initial begin
    tbl = '{
      '{4'b0000, 4'b0000}, '{4'b0001, 4'b0001}, '{4'b0010, 4'b0011}, '{4'b0011, 4'b0011},
      '{4'b0100, 4'b0111}, '{4'b0101, 4'b0111}, '{4'b0110, 4'b0111}, '{4'b0111, 4'b0111},
      '{4'b1000, 4'b1111}, '{4'b1001, 4'b1111}, '{4'b1010, 4'b1111}, '{4'b1011, 4'b1111},
      '{4'b1100, 4'b1111}, '{4'b1101, 4'b1111}, '{4'b1110, 4'b1111}, '{4'b1111, 4'b1111}
    };
    rst = 1'b1;
    clear_inputs();
    #2;
    do_reset();

    // Merge table in RUN
    foreach (tbl[i]) begin
      {r_cm, r_ex, r_id, r_if} = tbl[i].req;
      #1;
      check($sformatf("merge[%0d]", i), 32'(stall), 32'(tbl[i].exp_stall));
      step($sformatf("merge_step[%0d]", i));
    end

    // Issue stall for three cycles
    do_reset();
    r_id = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("id_hold/stall", 32'(stall), 32'h3);
      step("id_hold");
    end
    check("id_hold/count", stall_cycles, 32'd3);
    clear_inputs();
    step("idle");
    r_if = 1'b1; r_ex = 1'b1;
    #1; check("if_ex/stall", 32'(stall), 32'h7);
    step("if_ex");
    r_cm = 1'b1;
    #1; check("if_ex_cm/stall", 32'(stall), 32'hF);
    step("if_ex_cm");
    clear_inputs();

    // Exception beats a simultaneous mispredict
    exc = 1'b1; esel = 1'b0; etgt = 32'hBFC00380; bp = 1'b1; btgt = 32'h12345678;
    #1;
    check("exc/flush", 32'(flush), 32'h1);
    check("exc/cause", 32'(flush_cause), 32'h1);
    check("exc/new_pc", new_pc, 32'hBFC00380);
    check("exc/stall", 32'(stall), 32'h0);
    step("exc");
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      #1; check("exc_hold/stall", 32'(stall), 32'h1);
      step("exc_hold");
    end
    ack = 1'b1;
    #1; check("exc_ack/stall", 32'(stall), 32'h0);
    step("exc_ack");
    clear_inputs();
    step("after_ack");

    // Mispredict with execute stall; ack in the flush cycle is ignored
    bp = 1'b1; btgt = 32'h80001000; r_ex = 1'b1; ack = 1'b1;
    #1;
    check("bp/stall", 32'(stall), 32'h0);
    check("bp/cause", 32'(flush_cause), 32'h0);
    step("bp");
    bp = 1'b0; ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1; check("bp_hold/stall", 32'(stall), 32'h7);
      check("bp_hold/new_pc", new_pc, 32'h80001000);
      step("bp_hold");
    end
    ack = 1'b1;
    step("bp_ack");
    clear_inputs();
    #1; check("bp_run/stall", 32'(stall), 32'h0);
    step("bp_run");

    // Re-flush from REDIRECT; mispredict there is ignored
    bp = 1'b1; btgt = 32'h80002000;
    step("re_enter");
    exc = 1'b1; esel = 1'b1; etgt = 32'hBFC00200;
    #1;
    check("reflush/flush", 32'(flush), 32'h1);
    check("reflush/new_pc", new_pc, 32'hBFC00200);
    check("reflush/sel", 32'(exception_inst_sel), 32'h1);
    step("reflush");
    exc = 1'b0; btgt = 32'h80003000;
    #1;
    check("redir_bp/flush", 32'(flush), 32'h0);
    check("redir_bp/new_pc", new_pc, 32'hBFC00200);
    step("redir_bp");
    clear_inputs();
    ack = 1'b1;
    step("reflush_ack");
    clear_inputs();

    // Watchdog
    do_reset();
    r_if = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step("wd_hold");
      if (i == 7) check("wd/before", 32'(stall_timeout), 32'h0);
    end
    check("wd/set", 32'(stall_timeout), 32'h1);
    r_if = 1'b0;
    step("wd_drop");
    step("wd_drop");
    check("wd/sticky", 32'(stall_timeout), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("wd/async_clr", 32'(stall_timeout), 32'h0);
    check("wd/async_cnt", stall_cycles, 32'h0);
    do_reset();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      r_if = ($urandom_range(3) == 0);
      r_id = ($urandom_range(4) == 0);
      r_ex = ($urandom_range(4) == 0);
      r_cm = ($urandom_range(7) == 0);
      exc  = ($urandom_range(19) == 0);
      esel = 1'($urandom);
      etgt = $urandom;
      bp   = ($urandom_range(9) == 0);
      btgt = $urandom;
      ack  = ($urandom_range(2) == 0);
      step($sformatf("rand[%0d]", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
